// File: rtl/execute_feedback_arbiter.sv
// Execute feedback arbiter: one holding register per execute-unit channel
// (ALU, BRU, CSR, DIV, LSU, MUL), drained round-robin onto a small set of
// registered register-file write ports.
module execute_feedback_arbiter #(
    parameter int CH_NUM       = 6,
    parameter int WB_PORT_NUM  = 2,
    parameter int PHY_ID_WIDTH = 6,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic [CH_NUM-1:0]                   req_enable,
    input  logic [CH_NUM*PHY_ID_WIDTH-1:0]      req_phy_id,
    input  logic [CH_NUM*DATA_WIDTH-1:0]        req_value,
    output logic [CH_NUM-1:0]                   req_ready,
    output logic [WB_PORT_NUM-1:0]              wb_enable,
    output logic [WB_PORT_NUM*PHY_ID_WIDTH-1:0] wb_phy_id,
    output logic [WB_PORT_NUM*DATA_WIDTH-1:0]   wb_value,
    output logic [31:0]                         conflict_cnt
);

    localparam int PTR_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int IDX_W = PTR_W + 1;
    localparam int CNT_W = $clog2(CH_NUM + 1);
    localparam logic [IDX_W-1:0] CH_NUM_IDX = IDX_W'(CH_NUM);
    localparam logic [IDX_W-1:0] CH_LAST    = IDX_W'(CH_NUM - 1);

    logic [CH_NUM-1:0]       hold_valid_q, hold_valid_d;
    logic [PHY_ID_WIDTH-1:0] hold_phy_id_q [CH_NUM];
    logic [DATA_WIDTH-1:0]   hold_value_q  [CH_NUM];
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d, next_ptr;

    logic [WB_PORT_NUM-1:0]              wb_enable_q;
    logic [WB_PORT_NUM*PHY_ID_WIDTH-1:0] wb_phy_id_q;
    logic [WB_PORT_NUM*DATA_WIDTH-1:0]   wb_value_q;
    logic [31:0]                         conflict_cnt_q;

    // Scan order is realised by rotating hold_valid so bit 0 is the rr_ptr channel.
    logic [CH_NUM-1:0]      hold_rot, grant_rot, grant, xfer;
    logic [WB_PORT_NUM-1:0] port_vld;
    logic [PTR_W-1:0]       port_sel [WB_PORT_NUM];
    logic [IDX_W-1:0]       scan_idx;
    logic [CNT_W-1:0]       hv_cnt;
    logic                   oversub;
    int                     n_gnt;

    assign hold_rot = CH_NUM'({hold_valid_q, hold_valid_q} >> rr_ptr_q);
    assign grant    = CH_NUM'(({grant_rot, grant_rot} << rr_ptr_q) >> CH_NUM);

    // Pick the first WB_PORT_NUM held channels in round-robin order; n-th grant drives port n.
    always_comb begin
        n_gnt     = 0;
        grant_rot = '0;
        port_vld  = '0;
        next_ptr  = rr_ptr_q;
        scan_idx  = '0;
        for (int k = 0; k < WB_PORT_NUM; k++) port_sel[k] = '0;
        for (int j = 0; j < CH_NUM; j++) begin
            scan_idx = {1'b0, rr_ptr_q} + IDX_W'(j);
            if (scan_idx >= CH_NUM_IDX) scan_idx = scan_idx - CH_NUM_IDX;
            if (hold_rot[j] && (n_gnt < WB_PORT_NUM)) begin
                grant_rot[j] = 1'b1;
                for (int k = 0; k < WB_PORT_NUM; k++) begin
                    if (k == n_gnt) begin
                        port_vld[k] = 1'b1;
                        port_sel[k] = scan_idx[PTR_W-1:0];
                    end
                end
                next_ptr = (scan_idx == CH_LAST) ? '0 : scan_idx[PTR_W-1:0] + 1'b1;
                n_gnt    = n_gnt + 1;
            end
        end
    end

    // Ready depends only on held state and flush, never on req_enable.
    assign req_ready = {CH_NUM{!flush}} & (~hold_valid_q | grant);
    assign xfer      = req_enable & req_ready;

    // Next held-valid and pointer: flush wins, a new transfer refills a granted slot.
    always_comb begin
        hold_valid_d = flush ? '0 : (xfer | (hold_valid_q & ~grant));
        rr_ptr_d     = flush ? '0 : ((|port_vld) ? next_ptr : rr_ptr_q);
    end

    // Occupancy count for the oversubscription statistic.
    always_comb begin
        hv_cnt = '0;
        for (int c = 0; c < CH_NUM; c++) hv_cnt = hv_cnt + CNT_W'(hold_valid_q[c]);
        oversub = (hv_cnt > CNT_W'(WB_PORT_NUM));
    end

    // Control state: held-valid flags and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid_q <= '0;
            rr_ptr_q     <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    // Holding-register payload captured on each accepted handshake.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CH_NUM; c++) begin
            if (xfer[c]) begin
                hold_phy_id_q[c] <= req_phy_id[c*PHY_ID_WIDTH +: PHY_ID_WIDTH];
                hold_value_q[c]  <= req_value[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Registered write ports; unused ports keep their last id/value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_enable_q <= '0;
            wb_phy_id_q <= '0;
            wb_value_q  <= '0;
        end else if (flush) begin
            wb_enable_q <= '0;
        end else begin
            wb_enable_q <= port_vld;
            for (int k = 0; k < WB_PORT_NUM; k++) begin
                if (port_vld[k]) begin
                    wb_phy_id_q[k*PHY_ID_WIDTH +: PHY_ID_WIDTH] <= hold_phy_id_q[port_sel[k]];
                    wb_value_q[k*DATA_WIDTH +: DATA_WIDTH]      <= hold_value_q[port_sel[k]];
                end
            end
        end
    end

    // Saturating oversubscription counter; survives flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt_q <= '0;
        end else if (oversub && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
            conflict_cnt_q <= conflict_cnt_q + 32'd1;
        end
    end

    assign wb_enable    = wb_enable_q;
    assign wb_phy_id    = wb_phy_id_q;
    assign wb_value     = wb_value_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: doc/execute_feedback_arbiter.md
# execute_feedback_arbiter

Shares the physical-register-file write ports among the execute-unit feedback channels. Execute units are ALU, BRU, CSR, DIV, LSU and MUL, ordered the same way as in `execute_feedback_pack`. Each channel delivers one (phy_id, value) result per handshake into a one-entry holding register. A round-robin scheduler drains up to `WB_PORT_NUM` held results per cycle onto registered write ports, back-pressuring channels that lose arbitration.

## Interface
Parameters:
- `CH_NUM`, 6: number of feedback channels; bit i is channel i.
- `WB_PORT_NUM`, 2: register-file write ports; 1 ≤ `WB_PORT_NUM` ≤ `CH_NUM`.
- `PHY_ID_WIDTH`, 6: physical register id width.
- `DATA_WIDTH`, 32: result width.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous pipeline flush.
- `req_enable`  in  `CH_NUM`  channel i offers a result.
- `req_phy_id`  in  `CH_NUM*PHY_ID_WIDTH`  channel i id, slice [i*W +: W].
- `req_value`  in  `CH_NUM*DATA_WIDTH`  channel i value, sliced the same way.
- `req_ready`  out  `CH_NUM`  channel i can accept this cycle.
- `wb_enable`  out  `WB_PORT_NUM`  write port k valid (registered).
- `wb_phy_id`  out  `WB_PORT_NUM*PHY_ID_WIDTH`  write port k id (registered).
- `wb_value`  out  `WB_PORT_NUM*DATA_WIDTH`  write port k data (registered).
- `conflict_cnt`  out  32  saturating count of oversubscribed cycles.

## Operation
- State per channel:
  - `hold_valid[i]`, `hold_phy_id[i]`, `hold_value[i]`.
  - Global state: `rr_ptr`, `$clog2(CH_NUM)` bits, and `conflict_cnt`.
- Grant selection (combinational):
  - Scan channels rr_ptr, rr_ptr+1, … wrapping modulo `CH_NUM`.
  - The first `WB_PORT_NUM` channels with `hold_valid` set receive `grant`.
  - The n-th granted channel in scan order drives write port n.
  - Granted ports are always contiguous from port 0.
- `req_ready[i] = !flush && (!hold_valid[i] || grant[i])`. This gives a one-result-per-cycle sustained rate per channel when granted.
- Handshake: a transfer occurs when `req_enable[i] && req_ready[i]`. The holding register loads at the edge. If no transfer occurs, `hold_valid[i]` clears only when the channel is granted.
- If `req_enable` is asserted while `req_ready` = 0, the channel must hold its data stable. The arbiter captures nothing that cycle.
- Write ports (registered):
  - `wb_enable[n]` = 1 with the granted channel's id and value.
  - Unused ports: `wb_enable` = 0; id and value hold their previous contents (don't care).
- rr_ptr update:
  - On any grant: rr_ptr ← (index of last granted channel in scan order + 1) mod `CH_NUM`.
  - No grant: unchanged.
- `conflict_cnt`:
  - Increments when popcount(`hold_valid`) > `WB_PORT_NUM`.
  - Saturates at 0xFFFF_FFFF.
  - Not cleared by flush.
- Flush (highest priority):
  - At the edge, clears all `hold_valid`, `wb_enable` and rr_ptr (to 0).
  - `req_ready` = 0 during the flush cycle; offered inputs are dropped.
  - The grants computed in that cycle are discarded.

## Timing
- Reset values:
  - Output `req_ready` = all 1s. This is combinational from the reset state (hold empty, flush low), not a reset register.
  - Output registers: `wb_enable` = 0, `wb_phy_id` = 0, `wb_value` = 0, `conflict_cnt` = 0.
  - Internal state: `hold_valid` = 0, rr_ptr = 0.
- Latency: result accepted at edge t → held in cycle t+1 → on `wb_*` in cycle t+2 if granted. Minimum is 2 cycles.
- An ungranted entry waits. It is guaranteed a grant within ⌈`CH_NUM`/`WB_PORT_NUM`⌉ cycles of arbitration, so there is no starvation.
- Simultaneous grant and new transfer on the same channel: the old entry goes to the port and the new one is loaded. No bubble, no loss.
- Reset asserted mid-operation: all state clears immediately (asynchronous). Held results are lost.
- No combinational path from `req_enable` to `req_ready`.

## Test plan
- Reset:
  - Assert `rst` mid-cycle with entries held.
  - Required: `wb_enable`=0, `conflict_cnt`=0 and `req_ready`=6'b111111 immediately, before any clock edge.
- Single result:
  - Channel 3 sends phy_id 0x15, value 0xDEADBEEF at edge 1.
  - Required: `wb_enable`=2'b01, port 0 = {0x15, 0xDEADBEEF} in cycle 3.
  - Required: `wb_enable`=0 in cycle 4.
- Oversubscription (rr_ptr=0):
  - All 6 channels send in the same cycle.
  - Required grants: ports = ch0/ch1, then ch2/ch3, then ch4/ch5 on consecutive cycles.
  - Required: `req_ready` for the waiting channels stays 0 until they are granted.
  - Required: `conflict_cnt` = 2 (held counts 6 and 4).
- Back-to-back:
  - Channel 0 streams 4 results on consecutive cycles, all other channels idle.
  - Required: 4 consecutive port-0 writes in order; `req_ready[0]` stays 1.
- Wrap-around:
  - Force rr_ptr=5, with channels 5, 0 and 1 held.
  - Required: port0=ch5, port1=ch0; next cycle port0=ch1; rr_ptr=2.
- Flush:
  - Assert `flush` with channels 2 and 4 held while channel 1 offers a result.
  - Required: `req_ready`=0 in the flush cycle.
  - Required next cycle: `hold_valid`=0, `wb_enable`=0, rr_ptr=0.
  - Required: channel 1's result is never written.
